multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, setting the width of the retired-instruction counter.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, a synchronous active-low reset.
REQ-004 The block SHALL have port opcode, input, 6, instruction bits [31:26] from the IR, valid from DECODE onward.
REQ-005 The block SHALL have port mem_ready, input, 1, memory-access-complete strobe for the current cycle.
REQ-006 The block SHALL have outputs pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write and alu_src_a, 1 bit each, as datapath enables and selects.
REQ-007 The block SHALL have outputs alu_src_b, alu_op and pc_src, 2 bits each.
REQ-008 The block SHALL have output state, 4 bits, the current FSM state encoding.
REQ-009 The block SHALL have output illegal_op, 1 bit, a one-cycle pulse on an undecodable opcode.
REQ-010 The block SHALL have output retired, CNT_W bits, the count of completed instructions.

Function
REQ-011 The block SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, ADDIEX, ADDIWB, BRANCH and JUMP; every output not listed for a state SHALL be 0.
REQ-012 FETCH SHALL drive mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00, and ir_write=pc_write=mem_ready; it SHALL hold while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-013 DECODE SHALL drive alu_src_a=0, alu_src_b=11, alu_op=00 and branch on opcode: 000000->EXEC, 001000->ADDIEX, 000100->BRANCH, 000010->JUMP, 100011/101011->MEMADR.
REQ-014 In DECODE, any other opcode SHALL return to FETCH with illegal_op=1 for that DECODE cycle only, with no register or memory write.
REQ-015 MEMADR SHALL drive alu_src_a=1, alu_src_b=10, alu_op=00, then go to MEMRD if opcode=100011, else MEMWR.
REQ-016 MEMRD SHALL drive mem_read=1, iord=1, hold while mem_ready=0, and go to MEMWB when mem_ready=1.
REQ-017 MEMWB SHALL drive reg_write=1, mem_to_reg=1, reg_dst=0, then go to FETCH.
REQ-018 MEMWR SHALL drive mem_write=1, iord=1, hold while mem_ready=0, and go to FETCH when mem_ready=1.
REQ-019 EXEC SHALL drive alu_src_a=1, alu_src_b=00, alu_op=10, then go to ALUWB; ALUWB SHALL drive reg_write=1, reg_dst=1, mem_to_reg=0, then go to FETCH.
REQ-020 ADDIEX SHALL drive alu_src_a=1, alu_src_b=10, alu_op=00, then go to ADDIWB; ADDIWB SHALL drive reg_write=1, reg_dst=0, mem_to_reg=0, then go to FETCH.
REQ-021 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=01, then go to FETCH.
REQ-022 JUMP SHALL drive pc_write=1, pc_src=10, then go to FETCH.
REQ-023 With mem_ready held at 1, instruction latencies SHALL be: add 4, addi 4, beq 3, j 3, sw 4, lw 5 cycles; each mem_ready=0 cycle in FETCH, MEMRD or MEMWR SHALL add exactly one cycle.
REQ-024 retired SHALL increment by 1 on each transition into FETCH from MEMWB, MEMWR (with mem_ready=1), ALUWB, ADDIWB, BRANCH or JUMP, and SHALL NOT increment on an illegal-opcode return.
REQ-025 retired SHALL wrap modulo 2^CNT_W.
REQ-026 mem_write and reg_write SHALL never both be 1 in the same cycle, and no output SHALL be X in any state.

Reset
REQ-027 While rst_n=0 at a rising edge of clk, state SHALL become FETCH and retired SHALL become 0; this SHALL take priority over any transition, including mid-instruction or mid-stall.
REQ-028 During reset, outputs SHALL take FETCH values, with ir_write and pc_write still gated by mem_ready.
REQ-029 Unused state encodings SHALL transition to FETCH on the next edge.

Structure
REQ-030 The state encoding, opcode constants (OP_RTYPE, OP_ADDI, OP_BEQ, OP_J, OP_LW, OP_SW) and alu_op/alu_src_b/pc_src codes SHALL reside in a shared package, mips_ctrl_pkg.
REQ-031 Output decode SHALL be one combinational process inside this module, with no sub-module.
REQ-032 The retired counter SHALL be the sub-module instr_counter (enable, clear, CNT_W-bit wrap).

Verification
REQ-033 Reset, then opcode=000000 with mem_ready=1 -> states FETCH, DECODE, EXEC, ALUWB, FETCH; reg_write=1, reg_dst=1 in ALUWB only; retired=1.
REQ-034 opcode=100011, mem_ready=0 for 2 cycles in MEMRD -> lw takes 7 cycles; mem_read=iord=1 throughout MEMRD; mem_to_reg=1 in MEMWB.
REQ-035 opcode=101011, mem_ready=1 -> mem_write=1 for exactly one cycle; reg_write never asserted; retired +1.
REQ-036 opcode=000100, then 000010 -> BRANCH with pc_write_cond=1, pc_src=01, then JUMP with pc_write=1, pc_src=10; 3 cycles each.
REQ-037 opcode=111111 -> illegal_op=1 for exactly the DECODE cycle, next state FETCH, retired unchanged.
REQ-038 rst_n=0 asserted in MEMRD during a stall -> next state FETCH, retired=0; CNT_W=4 with 16 add instructions -> retired wraps to 0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit: state encoding,
// opcode constants, datapath select codes and the bundled control word.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        ADDIEX = 4'd8,
        ADDIWB = 4'd9,
        BRANCH = 4'd10,
        JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // ALU operation class handed to the ALU decoder.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B-operand select.
    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BROFF = 2'b11;

    // Next-PC source select.
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Every datapath control in one word so the decoder can clear them all at once.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       illegal_op;
    } ctrl_t;

endpackage

// File: rtl/instr_counter.sv
// Retired-instruction counter: synchronous clear, count enable, wraps at 2^CNT_W.
module instr_counter
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count
);

    // Clear wins over enable; natural overflow provides the wrap.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
        if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control unit: Moore FSM driving datapath enables/selects,
// flagging undecodable opcodes and counting retired instructions.
module multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic [3:0]       state,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired
);

    state_t state_q;
    state_t state_d;
    state_t cur_state;
    ctrl_t  ctrl;
    logic   retire;
    logic   cnt_clear;

    // While reset is held the block presents FETCH, so outputs are defined
    // even before the first edge has loaded the state register.
    assign cur_state = rst_n ? state_q : FETCH;
    assign cnt_clear = ~rst_n;

    // State register; reset overrides any pending transition, including stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, Moore output decode and retire strobe for the current state.
    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        state_d = FETCH;
        ctrl    = '0;
        retire  = 1'b0;

        case (cur_state)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_src    = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
                state_d        = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ctrl.alu_src_b = SRCB_BROFF;
                ctrl.alu_op    = ALUOP_ADD;
                case (opcode)
                    OP_RTYPE:     state_d = EXEC;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    OP_LW, OP_SW: state_d = MEMADR;
                    default: begin
                        // Undecodable: drop the instruction without retiring it.
                        ctrl.illegal_op = 1'b1;
                        state_d         = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
                state_d        = (opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
                state_d       = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                retire          = 1'b1;
            end
            MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
                state_d        = mem_ready ? FETCH : MEMWR;
                retire         = mem_ready;
            end
            EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
                state_d        = ALUWB;
            end
            ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                retire         = 1'b1;
            end
            ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
                state_d        = ADDIWB;
            end
            ADDIWB: begin
                ctrl.reg_write = 1'b1;
                retire         = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_src        = PCSRC_ALUOUT;
                retire             = 1'b1;
            end
            JUMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PCSRC_JUMP;
                retire        = 1'b1;
            end
            default: begin
                // Unused encodings recover to FETCH with all outputs low.
                state_d = FETCH;
            end
        endcase
    end

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign iord          = ctrl.iord;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_src        = ctrl.pc_src;
    assign illegal_op    = ctrl.illegal_op;
    assign state         = cur_state;

    instr_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk    (clk),
        .clear  (cnt_clear),
        .enable (retire),
        .count  (retired)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: an instruction-level model expands each
// instruction into its expected cycle sequence; a monitor compares every cycle.
module tb_multicycle_ctrl;
    import mips_ctrl_pkg::*;

    typedef enum {K_ADD, K_ADDI, K_BEQ, K_J, K_LW, K_SW, K_ILL} kind_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       illegal_op;
    } outs_t;

    typedef struct {
        state_t st;
        bit     rdy;
        bit     ill;
    } cyc_t;

    typedef struct {
        state_t      st;
        outs_t       o;
        logic [15:0] ret;
        logic [3:0]  ret4;
        int          id;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;

    logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic        mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0]  alu_src_b, alu_op, pc_src;
    logic [3:0]  state;
    logic [15:0] retired;

    logic        w4_pc_write, w4_pc_write_cond, w4_iord, w4_mem_read, w4_mem_write, w4_ir_write;
    logic        w4_mem_to_reg, w4_reg_dst, w4_reg_write, w4_alu_src_a, w4_illegal_op;
    logic [1:0]  w4_alu_src_b, w4_alu_op, w4_pc_src;
    logic [3:0]  w4_state;
    logic [3:0]  w4_retired;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_src(pc_src), .state(state), .illegal_op(illegal_op), .retired(retired)
    );

    multicycle_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(w4_pc_write), .pc_write_cond(w4_pc_write_cond), .iord(w4_iord),
        .mem_read(w4_mem_read), .mem_write(w4_mem_write), .ir_write(w4_ir_write),
        .mem_to_reg(w4_mem_to_reg), .reg_dst(w4_reg_dst), .reg_write(w4_reg_write),
        .alu_src_a(w4_alu_src_a), .alu_src_b(w4_alu_src_b), .alu_op(w4_alu_op),
        .pc_src(w4_pc_src), .state(w4_state), .illegal_op(w4_illegal_op), .retired(w4_retired)
    );

    outs_t act_o, act4_o;
    assign act_o  = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                     mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                     pc_src, illegal_op};
    assign act4_o = {w4_pc_write, w4_pc_write_cond, w4_iord, w4_mem_read, w4_mem_write,
                     w4_ir_write, w4_mem_to_reg, w4_reg_dst, w4_reg_write, w4_alu_src_a,
                     w4_alu_src_b, w4_alu_op, w4_pc_src, w4_illegal_op};

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cnt   = 0;
    int   cyc_id = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp, input int id);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, id, act, exp);
        end
    endtask

    // Output table for each control step, written from the instruction-step definitions.
    function automatic outs_t exp_outs(state_t s, bit rdy, bit ill);
        outs_t o;
        o = '0;
        case (s)
            FETCH:  begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_write = rdy; end
            DECODE: begin o.alu_src_b = 2'b11; o.illegal_op = ill; end
            MEMADR: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            MEMRD:  begin o.mem_read = 1; o.iord = 1; end
            MEMWB:  begin o.reg_write = 1; o.mem_to_reg = 1; end
            MEMWR:  begin o.mem_write = 1; o.iord = 1; end
            EXEC:   begin o.alu_src_a = 1; o.alu_op = 2'b10; end
            ALUWB:  begin o.reg_write = 1; o.reg_dst = 1; end
            ADDIEX: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            ADDIWB: begin o.reg_write = 1; end
            BRANCH: begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_write_cond = 1; o.pc_src = 2'b01; end
            JUMP:   begin o.pc_write = 1; o.pc_src = 2'b10; end
            default: ;
        endcase
        return o;
    endfunction

    function automatic logic [5:0] op_of(kind_t k);
        logic [5:0] op;
        case (k)
            K_ADD:  op = 6'b000000;
            K_ADDI: op = 6'b001000;
            K_BEQ:  op = 6'b000100;
            K_J:    op = 6'b000010;
            K_LW:   op = 6'b100011;
            K_SW:   op = 6'b101011;
            default: begin
                do op = 6'($urandom);
                while (op inside {6'b000000, 6'b001000, 6'b000100, 6'b000010, 6'b100011, 6'b101011});
            end
        endcase
        return op;
    endfunction

    function automatic cyc_t mk(state_t s, bit r, bit i);
        cyc_t c;
        c.st = s; c.rdy = r; c.ill = i;
        return c;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cycle(state_t s, bit rdy, bit ill);
        exp_t e;
        e.st   = s;
        e.o    = exp_outs(s, rdy, ill);
        e.ret  = 16'(cnt % 65536);
        e.ret4 = 4'(cnt % 16);
        e.id   = cyc_id;
        cyc_id++;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        mem_ready = 1'($urandom);
        opcode    = 6'($urandom);
        expect_cycle(FETCH, mem_ready, 1'b0);
        step();
        cnt   = 0;
        rst_n = 1'b1;
    endtask

    // Expand one instruction into its cycle list, then drive it; rst_at aborts with reset.
    task automatic run_instr(kind_t k, int fstall, int mstall, int rst_at);
        cyc_t       seq[$];
        logic [5:0] op;
        op = op_of(k);
        for (int i = 0; i < fstall; i++) seq.push_back(mk(FETCH, 1'b0, 1'b0));
        seq.push_back(mk(FETCH, 1'b1, 1'b0));
        seq.push_back(mk(DECODE, 1'($urandom), k == K_ILL));
        case (k)
            K_ADD:  begin seq.push_back(mk(EXEC, 1'($urandom), 0)); seq.push_back(mk(ALUWB, 1'($urandom), 0)); end
            K_ADDI: begin seq.push_back(mk(ADDIEX, 1'($urandom), 0)); seq.push_back(mk(ADDIWB, 1'($urandom), 0)); end
            K_BEQ:  seq.push_back(mk(BRANCH, 1'($urandom), 0));
            K_J:    seq.push_back(mk(JUMP, 1'($urandom), 0));
            K_LW: begin
                seq.push_back(mk(MEMADR, 1'($urandom), 0));
                for (int i = 0; i < mstall; i++) seq.push_back(mk(MEMRD, 1'b0, 0));
                seq.push_back(mk(MEMRD, 1'b1, 0));
                seq.push_back(mk(MEMWB, 1'($urandom), 0));
            end
            K_SW: begin
                seq.push_back(mk(MEMADR, 1'($urandom), 0));
                for (int i = 0; i < mstall; i++) seq.push_back(mk(MEMWR, 1'b0, 0));
                seq.push_back(mk(MEMWR, 1'b1, 0));
            end
            default: ;
        endcase
        for (int i = 0; i < seq.size(); i++) begin
            mem_ready = seq[i].rdy;
            opcode    = (seq[i].st == FETCH) ? 6'($urandom) : op;
            if (i == rst_at) begin
                rst_n = 1'b0;
                expect_cycle(FETCH, seq[i].rdy, 1'b0);
                step();
                cnt   = 0;
                rst_n = 1'b1;
                return;
            end
            rst_n = 1'b1;
            expect_cycle(seq[i].st, seq[i].rdy, seq[i].ill);
            step();
        end
        if (k != K_ILL) cnt++;
    endtask

    // Monitor: every cycle with an outstanding expectation is compared away from the edge.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("state",    {28'b0, state},      {28'b0, e.st},  e.id);
            check("outs",     {15'b0, act_o},      {15'b0, e.o},   e.id);
            check("retired",  {16'b0, retired},    {16'b0, e.ret}, e.id);
            check("state4",   {28'b0, w4_state},   {28'b0, e.st},  e.id);
            check("outs4",    {15'b0, act4_o},     {15'b0, e.o},   e.id);
            check("retired4", {28'b0, w4_retired}, {28'b0, e.ret4}, e.id);
            check("memw_regw_excl", {31'b0, mem_write & reg_write}, 32'd0, e.id);
        end
    end

    initial begin
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        opcode    = 6'b0;
        step();
        do_reset();

        // Directed: each instruction class, stalls, illegal opcode.
        run_instr(K_ADD, 0, 0, -1);
        run_instr(K_LW, 0, 2, -1);
        run_instr(K_SW, 0, 0, -1);
        run_instr(K_BEQ, 0, 0, -1);
        run_instr(K_J, 0, 0, -1);
        run_instr(K_ILL, 0, 0, -1);
        run_instr(K_ADDI, 2, 0, -1);
        run_instr(K_SW, 1, 3, -1);

        // Reset during the second MEMRD stall cycle of a load.
        run_instr(K_LW, 0, 3, 4);
        run_instr(K_ADD, 0, 0, -1);

        // Sixteen adds from a clean reset wrap the 4-bit counter.
        do_reset();
        for (int i = 0; i < 16; i++) run_instr(K_ADD, 0, 0, -1);
        check("wrap_cnt4",  {28'b0, w4_retired}, 32'd0,  cyc_id);
        check("wrap_cnt16", {16'b0, retired},    32'd16, cyc_id);

        // Random instruction mix with random stalls and occasional resets.
        for (int n = 0; n < 300; n++) begin
            kind_t k;
            int    ra;
            k  = kind_t'($urandom_range(0, 6));
            ra = ($urandom_range(0, 29) == 0) ? int'($urandom_range(0, 6)) : -1;
            run_instr(k, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), ra);
        end

        @(negedge clk);
        #1;
        check("sb_drained", sb.size(), 32'd0, cyc_id);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
